ingress_scheduler: RTL and testbench

Scheduler between the CVA6 multi-issue commit ports and the single-issue trace encoder. Accepts bundles of up to NrRetiredInstr retired uops per cycle and buffers them in program order. Runs of consecutive STD uops are compressed into a single emitted entry that carries a retirement count. Entries are drained one per cycle to the encoder over a valid/ready handshake.

---
 rtl/ingress_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_ingress_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ingress_scheduler.sv
// Commit-port to trace-encoder scheduler: buffers retired uops in program order,
// folds runs of STD uops into one counted entry and drains one entry per cycle.

package mure_pkg;
   typedef enum logic [2:0] {
      ITYPE_STD  = 3'd0,
      ITYPE_EXC  = 3'd1,
      ITYPE_INT  = 3'd2,
      ITYPE_ERET = 3'd3,
      ITYPE_UJ   = 3'd4
   } itype_e;

   typedef struct packed {
      itype_e      itype;
      logic [31:0] pc;
   } uop_entry_s;
endpackage

module ingress_scheduler #(
   parameter int unsigned NrRetiredInstr = 4,
   parameter int unsigned Depth          = 16,
   parameter int unsigned MaxRun         = 15,
   parameter int unsigned IretW          = $clog2(MaxRun + 2)
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic [NrRetiredInstr-1:0]                 ivalids_i,
   input  mure_pkg::uop_entry_s [NrRetiredInstr-1:0] uops_i,
   output logic                                      ready_o,
   output logic                                      overflow_o,
   output logic                                      valid_o,
   output mure_pkg::uop_entry_s                      uop_o,
   output logic [IretW-1:0]                          iretire_o,
   input  logic                                      ready_i,
   output logic                                      empty_o
);
   import mure_pkg::*;

   localparam int unsigned PtrW  = $clog2(Depth);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned LaneW = $clog2(NrRetiredInstr + 1);
   localparam logic [CntW-1:0]  DepthC  = CntW'(Depth);
   localparam logic [CntW-1:0]  LanesC  = CntW'(NrRetiredInstr);
   localparam logic [IretW-1:0] MaxRunC = IretW'(MaxRun);

   uop_entry_s        mem_q [Depth];
   uop_entry_s        mem_d [Depth];
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [IretW-1:0]  acc_cnt_q, acc_cnt_d;
   uop_entry_s        acc_last_q, acc_last_d;
   logic              out_valid_q, out_valid_d;
   uop_entry_s        out_uop_q, out_uop_d;
   logic [IretW-1:0]  out_iret_q, out_iret_d;
   logic              overflow_q, overflow_d;

   logic              ready_s;
   logic              loadable_s;
   logic              run_s;
   logic [LaneW-1:0]  push_cnt_s;
   logic [LaneW-1:0]  pop_cnt_s;
   logic [PtrW-1:0]   widx_s;
   logic [PtrW-1:0]   ridx_s;
   uop_entry_s        head_s;

   // No credit for same-cycle pops, so a full bundle always fits when accepted.
   assign ready_s    = (DepthC - count_q) >= LanesC;
   assign loadable_s = !out_valid_q || ready_i;
   assign head_s     = mem_q[rd_ptr_q];

   // Enqueue: compact valid lanes in lane order, or drop the whole bundle.
   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      push_cnt_s = '0;
      widx_s     = wr_ptr_q;
      overflow_d = 1'b0;
      if (|ivalids_i) begin
         if (ready_s) begin
            for (int unsigned i = 0; i < NrRetiredInstr; i++) begin
               if (ivalids_i[i]) begin
                  widx_s        = wr_ptr_q + PtrW'(push_cnt_s);
                  mem_d[widx_s] = uops_i[i];
                  push_cnt_s    = push_cnt_s + LaneW'(1);
               end else begin
                  push_cnt_s = push_cnt_s;
               end
            end
            wr_ptr_d = wr_ptr_q + PtrW'(push_cnt_s);
         end else begin
            overflow_d = 1'b1;
         end
      end else begin
         overflow_d = 1'b0;
      end
   end

   // Drain: one prioritized action per cycle feeding the output register.
   always_comb begin
      out_valid_d = out_valid_q && !ready_i;
      out_uop_d   = out_uop_q;
      out_iret_d  = out_iret_q;
      acc_cnt_d   = acc_cnt_q;
      acc_last_d  = acc_last_q;
      pop_cnt_s   = '0;
      run_s       = 1'b1;
      ridx_s      = rd_ptr_q;
      if ((acc_cnt_q == MaxRunC) && loadable_s) begin
         out_valid_d = 1'b1;
         out_uop_d   = acc_last_q;
         out_iret_d  = MaxRunC;
         acc_cnt_d   = '0;
      end else if ((count_q != '0) && (head_s.itype != ITYPE_STD)) begin
         if (loadable_s) begin
            out_valid_d = 1'b1;
            out_uop_d   = head_s;
            out_iret_d  = acc_cnt_q + IretW'(1);
            acc_cnt_d   = '0;
            pop_cnt_s   = LaneW'(1);
         end else begin
            out_valid_d = out_valid_q && !ready_i;
         end
      end else if (count_q != '0) begin
         // Leading STD entries only, capped so the run never exceeds MaxRun.
         for (int unsigned i = 0; i < NrRetiredInstr; i++) begin
            ridx_s = rd_ptr_q + PtrW'(i);
            if (run_s && (CntW'(i) < count_q) &&
                (mem_q[ridx_s].itype == ITYPE_STD) &&
                ((32'(acc_cnt_q) + 32'(i) + 32'd1) <= 32'(MaxRun))) begin
               pop_cnt_s  = LaneW'(i + 32'd1);
               acc_last_d = mem_q[ridx_s];
            end else begin
               run_s = 1'b0;
            end
         end
         acc_cnt_d = acc_cnt_q + IretW'(pop_cnt_s);
      end else if ((acc_cnt_q != '0) && loadable_s) begin
         out_valid_d = 1'b1;
         out_uop_d   = acc_last_q;
         out_iret_d  = acc_cnt_q;
         acc_cnt_d   = '0;
      end else begin
         acc_cnt_d = acc_cnt_q;
      end
   end

   assign rd_ptr_d = rd_ptr_q + PtrW'(pop_cnt_s);
   assign count_d  = count_q + CntW'(push_cnt_s) - CntW'(pop_cnt_s);

   // Buffer storage; contents are only meaningful under count_q.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   // Control and output state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         acc_cnt_q   <= '0;
         acc_last_q  <= '0;
         out_valid_q <= 1'b0;
         out_uop_q   <= '0;
         out_iret_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_last_q  <= acc_last_d;
         out_valid_q <= out_valid_d;
         out_uop_q   <= out_uop_d;
         out_iret_q  <= out_iret_d;
         overflow_q  <= overflow_d;
      end
   end

   assign ready_o    = ready_s;
   assign overflow_o = overflow_q;
   assign valid_o    = out_valid_q;
   assign uop_o      = out_uop_q;
   assign iretire_o  = out_iret_q;
   assign empty_o    = (count_q == '0) && (acc_cnt_q == '0) && !out_valid_q;

endmodule

// File: tb/tb_ingress_scheduler.sv
// Directed bench for ingress_scheduler with hand-computed expectations.

module tb_ingress_scheduler;
   import mure_pkg::*;

   logic                   clk_i = 1'b0;
   logic                   rst_ni;
   logic [3:0]             ivalids_i;
   uop_entry_s [3:0]       uops_i;
   logic                   ready_o;
   logic                   overflow_o;
   logic                   valid_o;
   uop_entry_s             uop_o;
   logic [4:0]             iretire_o;
   logic                   ready_i;
   logic                   empty_o;

   int checks = 0;
   int errors = 0;
   int sum;

   uop_entry_s em_q[$];
   logic [4:0] ei_q[$];

   ingress_scheduler #(
      .NrRetiredInstr(4), .Depth(16), .MaxRun(15)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .ivalids_i(ivalids_i), .uops_i(uops_i),
      .ready_o(ready_o), .overflow_o(overflow_o), .valid_o(valid_o),
      .uop_o(uop_o), .iretire_o(iretire_o), .ready_i(ready_i), .empty_o(empty_o)
   );

   always #5 clk_i = ~clk_i;

   // Record every handshake that will complete at the next rising edge.
   always @(negedge clk_i) begin
      if (rst_ni && valid_o && ready_i) begin
         em_q.push_back(uop_o);
         ei_q.push_back(iretire_o);
      end
   end

   function automatic uop_entry_s mk(input itype_e t, input logic [31:0] pc);
      uop_entry_s u;
      u.itype = t;
      u.pc    = pc;
      return u;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      em_q.delete();
      ei_q.delete();
   endtask

   initial begin
      rst_ni    = 1'b0;
      ivalids_i = 4'b0000;
      uops_i    = '0;
      ready_i   = 1'b1;
      #1;
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_ovf", 64'(overflow_o), 64'd0);
      chk("rst_iret", 64'(iretire_o), 64'd0);
      chk("rst_uop", 64'(uop_o), 64'd0);
      chk("rst_empty", 64'(empty_o), 64'd1);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();

      // Single EXC: visible two cycles after acceptance.
      ivalids_i = 4'b0001;
      uops_i[0] = mk(ITYPE_EXC, 32'h100);
      tick();
      ivalids_i = 4'b0000;
      chk("t1_lat_early", 64'(valid_o), 64'd0);
      tick();
      chk("t1_valid", 64'(valid_o), 64'd1);
      chk("t1_pc", 64'(uop_o.pc), 64'h100);
      chk("t1_itype", 64'(uop_o.itype), 64'(ITYPE_EXC));
      chk("t1_iret", 64'(iretire_o), 64'd1);
      chk("t1_busy", 64'(empty_o), 64'd0);
      tick();
      chk("t1_drop", 64'(valid_o), 64'd0);
      chk("t1_empty", 64'(empty_o), 64'd1);
      clr();

      // Four STD then a UJ fold into one entry with iretire 5.
      ivalids_i = 4'b1111;
      for (int l = 0; l < 4; l++) uops_i[l] = mk(ITYPE_STD, 32'h200 + 32'(4 * l));
      tick();
      ivalids_i = 4'b0001;
      uops_i[0] = mk(ITYPE_UJ, 32'h210);
      tick();
      ivalids_i = 4'b0000;
      repeat (6) tick();
      chk("t2_count", 64'(em_q.size()), 64'd1);
      chk("t2_itype", 64'(em_q[0].itype), 64'(ITYPE_UJ));
      chk("t2_pc", 64'(em_q[0].pc), 64'h210);
      chk("t2_iret", 64'(ei_q[0]), 64'd5);
      clr();

      // Twenty STD: a saturated run of 15, then the remaining 5.
      for (int b = 0; b < 5; b++) begin
         ivalids_i = 4'b1111;
         for (int l = 0; l < 4; l++)
            uops_i[l] = mk(ITYPE_STD, 32'h1000 + 32'(4 * (4 * b + l)));
         tick();
      end
      ivalids_i = 4'b0000;
      repeat (10) tick();
      chk("t3_count", 64'(em_q.size()), 64'd2);
      chk("t3_iret0", 64'(ei_q[0]), 64'd15);
      chk("t3_pc0", 64'(em_q[0].pc), 64'h1038);
      chk("t3_iret1", 64'(ei_q[1]), 64'd5);
      chk("t3_pc1", 64'(em_q[1].pc), 64'h104C);
      sum = 0;
      foreach (ei_q[i]) sum += int'(ei_q[i]);
      chk("t3_sum", 64'(sum), 64'd20);
      chk("t3_empty", 64'(empty_o), 64'd1);
      clr();

      // Backpressure fills the buffer; a fifth bundle overflows.
      ready_i = 1'b0;
      for (int b = 0; b < 4; b++) begin
         chk("t4_ready_open", 64'(ready_o), 64'd1);
         ivalids_i = 4'b1111;
         for (int l = 0; l < 4; l++)
            uops_i[l] = mk(ITYPE_EXC, 32'h3000 + 32'(4 * (4 * b + l)));
         tick();
      end
      chk("t4_ready_closed", 64'(ready_o), 64'd0);
      for (int l = 0; l < 4; l++) uops_i[l] = mk(ITYPE_EXC, 32'h3040 + 32'(4 * l));
      chk("t4_ovf_before", 64'(overflow_o), 64'd0);
      tick();
      ivalids_i = 4'b0000;
      chk("t4_ovf_pulse", 64'(overflow_o), 64'd1);
      chk("t4_hold_valid", 64'(valid_o), 64'd1);
      chk("t4_hold_pc", 64'(uop_o.pc), 64'h3000);
      tick();
      chk("t4_ovf_clear", 64'(overflow_o), 64'd0);
      chk("t4_still_full", 64'(ready_o), 64'd0);
      chk("t4_hold_pc2", 64'(uop_o.pc), 64'h3000);
      chk("t4_hold_iret", 64'(iretire_o), 64'd1);
      ready_i = 1'b1;
      repeat (25) tick();
      chk("t4_count", 64'(em_q.size()), 64'd16);
      for (int i = 0; i < 16; i++) begin
         chk("t4_pc", 64'(em_q[i].pc), 64'h3000 + 64'(4 * i));
         chk("t4_iret", 64'(ei_q[i]), 64'd1);
      end
      chk("t4_empty", 64'(empty_o), 64'd1);
      clr();

      // Sparse lane pattern is compacted in lane order.
      ivalids_i = 4'b1010;
      uops_i[0] = mk(ITYPE_STD, 32'hBAD0);
      uops_i[1] = mk(ITYPE_INT, 32'h400);
      uops_i[2] = mk(ITYPE_STD, 32'hBAD4);
      uops_i[3] = mk(ITYPE_INT, 32'h404);
      tick();
      ivalids_i = 4'b0000;
      repeat (5) tick();
      chk("t5_count", 64'(em_q.size()), 64'd2);
      chk("t5_pc0", 64'(em_q[0].pc), 64'h400);
      chk("t5_pc1", 64'(em_q[1].pc), 64'h404);
      chk("t5_itype", 64'(em_q[1].itype), 64'(ITYPE_INT));
      chk("t5_iret0", 64'(ei_q[0]), 64'd1);
      chk("t5_iret1", 64'(ei_q[1]), 64'd1);
      clr();

      // Asynchronous reset with eight entries held discards everything.
      ready_i = 1'b0;
      for (int b = 0; b < 2; b++) begin
         ivalids_i = 4'b1111;
         for (int l = 0; l < 4; l++)
            uops_i[l] = mk(ITYPE_ERET, 32'h500 + 32'(4 * (4 * b + l)));
         tick();
      end
      ivalids_i = 4'b0000;
      tick();
      chk("t6_pre_valid", 64'(valid_o), 64'd1);
      chk("t6_pre_empty", 64'(empty_o), 64'd0);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(valid_o), 64'd0);
      chk("t6_rst_ready", 64'(ready_o), 64'd1);
      chk("t6_rst_empty", 64'(empty_o), 64'd1);
      tick();
      tick();
      rst_ni  = 1'b1;
      ready_i = 1'b1;
      clr();
      repeat (10) tick();
      chk("t6_no_stale", 64'(em_q.size()), 64'd0);
      chk("t6_empty", 64'(empty_o), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
